// File: rtl/program_loader.sv
// Byte-stream loader that writes instruction memory, data memory and register file words.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module program_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [1:0]            wr_target,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int         BYTES  = WORD_WIDTH / 8;
    localparam logic [7:0] HEADER = 8'hA5;
    localparam logic [7:0] LAST_BYTE = 8'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TARGET, S_ADDR, S_COUNT, S_DATA, S_CHECK, S_DONE
    } state_t;

    state_t                  state;
    logic [1:0]              tgt;
    logic [ADDR_WIDTH-1:0]   addr_cnt;
    logic [8:0]              remaining;
    logic [7:0]              byte_cnt;
    logic [WORD_WIDTH-1:0]   word_sr;
    logic                    accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum;
`endif

    assign accept = in_valid && in_ready;

    // Little-endian assembly: each new byte enters at the top and earlier bytes move down.
    function automatic logic [WORD_WIDTH-1:0] shift_in(input logic [WORD_WIDTH-1:0] sr,
                                                       input logic [7:0] b);
        logic [WORD_WIDTH+7:0] tmp;
        tmp = {b, sr};
        return tmp[WORD_WIDTH+7:8];
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            wr_en     <= 1'b0;
            wr_target <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            core_hold <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            tgt       <= '0;
            addr_cnt  <= '0;
            remaining <= '0;
            byte_cnt  <= '0;
            word_sr   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            wr_en    <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            in_ready <= 1'b1;
            case (state)
                S_IDLE: begin
                    // core_hold may still be high here for the error-pulse cycle; it drops next.
                    if (accept && in_data == HEADER) begin
                        state     <= S_TARGET;
                        core_hold <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end else begin
                        core_hold <= 1'b0;
                    end
                end
                S_TARGET: if (accept) begin
                    if (in_data >= 8'd3) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tgt   <= in_data[1:0];
                        state <= S_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        csum  <= csum ^ in_data;
`endif
                    end
                end
                S_ADDR: if (accept) begin
                    addr_cnt <= in_data[ADDR_WIDTH-1:0];
                    state    <= S_COUNT;
`ifdef LOADER_CHECKSUM_EN
                    csum     <= csum ^ in_data;
`endif
                end
                S_COUNT: if (accept) begin
                    remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    byte_cnt  <= '0;
                    state     <= S_DATA;
`ifdef LOADER_CHECKSUM_EN
                    csum      <= csum ^ in_data;
`endif
                end
                S_DATA: if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ in_data;
`endif
                    word_sr <= shift_in(word_sr, in_data);
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt  <= '0;
                        wr_en     <= 1'b1;
                        wr_data   <= shift_in(word_sr, in_data);
                        wr_addr   <= addr_cnt;
                        wr_target <= tgt;
                        addr_cnt  <= addr_cnt + 1'b1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= S_CHECK;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
`endif
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept) begin
                        if (in_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            error <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    core_hold <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default 32-bit words, 8-bit addresses).
module tb_program_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_en;
    logic [1:0]  wr_target;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        error;

    program_loader #(.WORD_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_target(wr_target), .wr_addr(wr_addr),
        .wr_data(wr_data), .core_hold(core_hold), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [1:0]  q_tgt[$];
    logic [7:0]  q_addr[$];
    logic [31:0] q_data[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    bit          hold_bad = 0;
    bit          both_seen = 0;
    logic        hdr_hold;
    logic [31:0] wv [0:3];

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            q_tgt.push_back(wr_target);
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (core_hold !== 1'b1) hold_bad = 1;
        end
        if (error === 1'b1) begin
            err_cnt++;
            if (core_hold !== 1'b1) hold_bad = 1;
        end
        if (done === 1'b1 && error === 1'b1) both_seen = 1;
    end

    task automatic clear_mon();
        q_tgt.delete(); q_addr.delete(); q_data.delete();
        done_cnt = 0; err_cnt = 0; hold_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clock); #1; end
        in_data = b; in_valid = 1'b1; ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL byte_accept: in_ready=%b for byte %h, required 1 within 100 cycles", in_ready, b);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] tgt, input logic [7:0] addr, input logic [7:0] cnt,
                              input int nwords, input int gapk);
        logic [7:0] cs;
        int n;
        n = 0;
        cs = tgt ^ addr ^ cnt;
        send_byte(8'hA5, 0);
        hdr_hold = core_hold;
        send_byte(tgt, 0);
        send_byte(addr, 0);
        send_byte(cnt, 0);
        for (int w = 0; w < nwords; w++) begin
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ wv[w][8*b +: 8];
                send_byte(wv[w][8*b +: 8], (gapk == 0) ? 0 : ((n * gapk) % 3));
                n++;
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`endif
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_write(input int idx, input logic [1:0] t, input logic [7:0] a,
                               input logic [31:0] d, input string name);
        checks++;
        if (q_tgt.size() <= idx) begin
            errors++;
            $display("FAIL %s: only %0d writes seen, required write #%0d", name, q_tgt.size(), idx);
        end else if (q_tgt[idx] !== t || q_addr[idx] !== a || q_data[idx] !== d) begin
            errors++;
            $display("FAIL %s: got tgt=%0d addr=%h data=%h, required tgt=%0d addr=%h data=%h",
                     name, q_tgt[idx], q_addr[idx], q_data[idx], t, a, d);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b required 0", wr_en); end
        checks++; if (wr_target !== 2'd0) begin errors++; $display("FAIL rst_wr_target: got %0d required 0", wr_target); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_wr_addr: got %h required 00", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data: got %h required 0", wr_data); end
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL rst_core_hold: got %b required 0", core_hold); end
        checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_pulses: done=%b error=%b required 0 0", done, error); end
        #19 reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_instr_load();
        clear_mon();
        wv[0] = 32'hF8800020; wv[1] = 32'hF8800022;
        send_frame(8'h00, 8'h00, 8'h02, 2, 0);
        checks++; if (hdr_hold !== 1'b1) begin errors++; $display("FAIL instr_hold_after_hdr: got %b required 1", hdr_hold); end
        checks++; if (q_tgt.size() != 2) begin errors++; $display("FAIL instr_write_count: got %0d required 2", q_tgt.size()); end
        check_write(0, 2'd0, 8'h00, 32'hF8800020, "instr_w0");
        check_write(1, 2'd0, 8'h01, 32'hF8800022, "instr_w1");
        checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL instr_done: done=%0d error=%0d required 1 0", done_cnt, err_cnt); end
        checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL instr_hold_in_done: core_hold low during done, required high"); end
        checks++; if (core_hold !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL instr_idle: core_hold=%b in_ready=%b required 0 1", core_hold, in_ready); end
    endtask

    task automatic test_wrap();
        clear_mon();
        wv[0] = 32'h00000023; wv[1] = 32'h00000016;
        send_frame(8'h01, 8'hFF, 8'h02, 2, 0);
        check_write(0, 2'd1, 8'hFF, 32'h00000023, "wrap_w0");
        check_write(1, 2'd1, 8'h00, 32'h00000016, "wrap_w1");
        checks++; if (err_cnt != 0 || done_cnt != 1) begin errors++; $display("FAIL wrap_status: done=%0d error=%0d required 1 0", done_cnt, err_cnt); end
    endtask

    task automatic test_bad_target();
        clear_mon();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        checks++; if (core_hold !== 1'b0) begin errors++; $display("FAIL garbage_hold: got %b required 0", core_hold); end
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        checks++; if (error !== 1'b1 || core_hold !== 1'b1) begin errors++; $display("FAIL bad_tgt_error: error=%b core_hold=%b required 1 1", error, core_hold); end
        @(posedge clock); #1;
        checks++; if (error !== 1'b0 || in_ready !== 1'b1 || core_hold !== 1'b0) begin
            errors++; $display("FAIL bad_tgt_idle: error=%b in_ready=%b core_hold=%b required 0 1 0", error, in_ready, core_hold);
        end
        repeat (2) @(posedge clock); #1;
        checks++; if (q_tgt.size() != 0 || done_cnt != 0 || err_cnt != 1) begin
            errors++; $display("FAIL bad_tgt_summary: writes=%0d done=%0d error=%0d required 0 0 1", q_tgt.size(), done_cnt, err_cnt);
        end
    endtask

    task automatic test_throttle();
        wv[0] = 32'h11223344; wv[1] = 32'hAABBCCDD; wv[2] = 32'hDEADBEEF; wv[3] = 32'h01020304;
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            send_frame(8'h02, 8'h0A, 8'h04, 4, (pass == 0) ? 0 : 2);
            check_write(0, 2'd2, 8'h0A, 32'h11223344, "rf_w0");
            check_write(1, 2'd2, 8'h0B, 32'hAABBCCDD, "rf_w1");
            check_write(2, 2'd2, 8'h0C, 32'hDEADBEEF, "rf_w2");
            check_write(3, 2'd2, 8'h0D, 32'h01020304, "rf_w3");
            checks++; if (q_tgt.size() != 4 || done_cnt != 1) begin
                errors++; $display("FAIL rf_count pass%0d: writes=%0d done=%0d required 4 1", pass, q_tgt.size(), done_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h99, 0); send_byte(8'h88, 0);
        #2 reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || core_hold !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: in_ready=%b core_hold=%b required 0 0", in_ready, core_hold); end
        checks++; if (wr_target !== 2'd0 || wr_addr !== 8'h00 || wr_data !== 32'h0) begin
            errors++; $display("FAIL mid_rst_data: tgt=%0d addr=%h data=%h required 0 00 0", wr_target, wr_addr, wr_data);
        end
        @(negedge clock); reset = 1'b1;
        repeat (3) @(posedge clock); #1;
        checks++; if (q_tgt.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL mid_rst_nowrite: writes=%0d done=%0d required 0 0", q_tgt.size(), done_cnt); end
        wv[0] = 32'h11223344;
        send_frame(8'h01, 8'h07, 8'h01, 1, 0);
        check_write(0, 2'd1, 8'h07, 32'h11223344, "post_rst_w0");
        checks++; if (q_tgt.size() != 1 || done_cnt != 1) begin errors++; $display("FAIL post_rst_count: writes=%0d done=%0d required 1 1", q_tgt.size(), done_cnt); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int pass = 0; pass < 2; pass++) begin
            clear_mon();
            send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h04, 0); send_byte(8'h01, 0);
            send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
            send_byte((pass == 0) ? 8'h0D : 8'h0C, 0);
            repeat (3) @(posedge clock); #1;
            check_write(0, 2'd0, 8'h04, 32'h12345678, "csum_w0");
            checks++;
            if (pass == 0 && (done_cnt != 1 || err_cnt != 0)) begin
                errors++; $display("FAIL csum_good: done=%0d error=%0d required 1 0", done_cnt, err_cnt);
            end else if (pass == 1 && (done_cnt != 0 || err_cnt != 1)) begin
                errors++; $display("FAIL csum_bad: done=%0d error=%0d required 0 1", done_cnt, err_cnt);
            end
        end
    endtask
`endif

    task automatic test_exclusive_pulses();
        checks++;
        if (both_seen !== 1'b0) begin errors++; $display("FAIL done_error_overlap: seen=%b required 0", both_seen); end
    endtask

    initial begin
        test_reset();
        test_instr_load();
        test_wrap();
        test_bad_target();
        test_throttle();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_exclusive_pulses();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
